tt_host_driver: RTL and testbench
=================================

Name: tt_host_driver

Overview:
- Fabric-side host for a TinyTapeout-style user project: drives the project's input side (UI_IN, UIO_IN, ENA, RST_N, clock enable) and samples its output side (UO_OUT, UIO_OUT, UIO_OE).
- Controlled by a valid/ready command stream; returns sampled project outputs on a valid/ready response stream.
- Placed in a fabric user design next to the project wrapper; replaces direct pad hookup for scripted bring-up and self-test.

Parameters:
- RESET_CYCLES, 8, default number of cycles tt_rst_n is held low (≥1).
- STEP_W, 16, width of the step counter and of cmd_data.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  2  0=SET_UI, 1=SET_UIO, 2=STEP, 3=RESET
- cmd_data  in  STEP_W  operand (see Behaviour)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_data  out  16  {uio_sample[7:0], uo_sample[7:0]}
- rsp_conflict  out  1  sticky UIO contention seen since last response
- tt_ui_in  out  8  to project UI_IN
- tt_uo_out  in  8  from project UO_OUT
- tt_uio_in  out  8  to project UIO_IN
- tt_uio_out  in  8  from project UIO_OUT
- tt_uio_oe  in  8  from project UIO_OE (1 = project drives)
- tt_ena  out  1  project enable
- tt_rst_n  out  1  project reset, active low
- tt_clk_en  out  1  project clock enable; one project clock edge per high cycle
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst high): all outputs are registered at 0 except tt_rst_n=0; ui_reg=0, uio_val=0, uio_mask=0, conflict=0. FSM = AUTO_RST.
- States: AUTO_RST, IDLE, RST_HOLD, STEP_RUN, RESP.
- AUTO_RST: entered from rst. tt_rst_n=0 and tt_clk_en=1 for RESET_CYCLES cycles, then IDLE. No response is produced. tt_ena=1 from the first cycle after rst.
- cmd_ready = (state==IDLE). It is 0 in every other state, including RESP.
- SET_UI: ui_reg <= cmd_data[7:0]. tt_ui_in is updated the cycle after acceptance. No response; stays in IDLE.
- SET_UIO: uio_val <= cmd_data[7:0] and uio_mask <= cmd_data[15:8]. No response.
- UIO resolution, per bit i, combinational:
  - tt_uio_in[i] = tt_uio_oe[i] ? tt_uio_out[i] : (uio_mask[i] ? uio_val[i] : 0).
  - tt_uio_oe[i] && uio_mask[i] sets conflict (sticky). The project wins.
- STEP, N = cmd_data:
  - Accepted at cycle t. tt_clk_en=1 for cycles t+1..t+N; counter loads N and decrements.
  - At t+N+1, tt_uo_out and resolved tt_uio_in are sampled into rsp_data and rsp_valid=1 (state RESP).
  - N=0: no tt_clk_en pulse; rsp_valid at t+1.
  - N=2^STEP_W-1 is legal; no wrap occurs.
- RESET, M = cmd_data ? cmd_data : RESET_CYCLES:
  - tt_rst_n=0 and tt_clk_en=1 for cycles t+1..t+M.
  - tt_rst_n returns to 1 at t+M+1, and the response is sampled in the same cycle.
  - ui_reg, uio_val and uio_mask are preserved.
- RESP: rsp_valid, rsp_data and rsp_conflict are held stable until rsp_ready. On the handshake cycle: conflict clears (unless set again that cycle), go to IDLE, cmd_ready=1 the next cycle.
- Commands are not pipelined. One command is outstanding at a time.
- rst mid-STEP, mid-RESET or in RESP: any pending response is dropped; rsp_valid=0 next cycle; re-enter AUTO_RST.
- busy = (state != IDLE).

Decomposition:
- Package tt_host_pkg:
  - op_e enum (SET_UI, SET_UIO, STEP, RESET).
  - state_e enum.
  - rsp_t struct {uio, uo, conflict}.
  - Default-constant localparams.
- Sub-module tt_uio_resolve: the per-bit bidirectional mux and conflict detect, purely combinational, 8 bits wide.
- tt_host_driver holds the FSM, counter and registers.

Test Plan:
- Release rst: tt_rst_n=0 for exactly 8 cycles with tt_clk_en=1, then cmd_ready=1; no rsp_valid.
- SET_UI 0xA5 then STEP 3, with project uo=~ui: exactly 3 tt_clk_en cycles, rsp_valid at t+4 with rsp_data[7:0]=0x5A.
- STEP 0: rsp_valid at t+1 with zero tt_clk_en pulses. Hold rsp_ready=0 for 5 cycles: rsp_data stable, cmd_ready=0 throughout.
- SET_UIO data=0x0F3C with project uio_oe=0x03, uio_out=0x02: tt_uio_in=0x0E; next STEP response has rsp_conflict=1. Following response has conflict=0.
- RESET data=0 then RESET data=3: tt_rst_n low 8 then 3 cycles; ui_reg unchanged afterwards.
- Assert rst at cycle 5 of STEP 100: tt_clk_en drops, no response emitted, AUTO_RST sequence restarts, ui_reg=0.

Source files
------------

// File: rtl/tt_host_pkg.sv
// ---------------------------------------------------------------------------
// tt_host_pkg
// Shared types and default constants for the TinyTapeout-style host driver.
//   op_e    : command opcodes carried on the command stream
//   state_e : host driver FSM states
//   rsp_t   : one sampled response (project UIO view, UO view, contention flag)
// ---------------------------------------------------------------------------
package tt_host_pkg;

   localparam int DEF_RESET_CYCLES = 8;
   localparam int DEF_STEP_W       = 16;

   typedef enum logic [1:0] {
      OP_SET_UI  = 2'd0,
      OP_SET_UIO = 2'd1,
      OP_STEP    = 2'd2,
      OP_RESET   = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_AUTO_RST = 3'd0,
      ST_IDLE     = 3'd1,
      ST_RST_HOLD = 3'd2,
      ST_STEP_RUN = 3'd3,
      ST_RESP     = 3'd4
   } state_e;

   typedef struct packed {
      logic [7:0] uio;
      logic [7:0] uo;
      logic       conflict;
   } rsp_t;

endpackage

// File: rtl/tt_host_driver_if.sv
// ---------------------------------------------------------------------------
// tt_host_driver_if
// Command / response streams between a controller and tt_host_driver.
//   cmd_valid/cmd_ready/cmd_op/cmd_data : command stream (controller -> driver)
//   rsp_valid/rsp_ready/rsp_data/rsp_conflict : response stream (driver -> controller)
// Modports: master = controller side, slave = driver side.
// ---------------------------------------------------------------------------
interface tt_host_driver_if
   import tt_host_pkg::*;
#(
   parameter int STEP_W = DEF_STEP_W
) ();

   logic              cmd_valid;
   logic              cmd_ready;
   op_e               cmd_op;
   logic [STEP_W-1:0] cmd_data;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [15:0]       rsp_data;
   logic              rsp_conflict;

   modport master (
      output cmd_valid, cmd_op, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_conflict
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_conflict
   );

endinterface

// File: rtl/tt_host_driver_uio_resolve.sv
// ---------------------------------------------------------------------------
// tt_uio_resolve
// Per-bit resolution of the project's bidirectional UIO pins, combinational.
//   uio_oe_i   : project output enables (1 = project drives the bit)
//   uio_out_i  : project-driven values
//   uio_mask_i : host-drive mask
//   uio_val_i  : host-driven values
//   uio_in_o   : value seen on the project's UIO_IN
//   conflict_o : some bit is driven by both sides (the project wins)
// ---------------------------------------------------------------------------
module tt_uio_resolve (
   input  logic [7:0] uio_oe_i,
   input  logic [7:0] uio_out_i,
   input  logic [7:0] uio_mask_i,
   input  logic [7:0] uio_val_i,
   output logic [7:0] uio_in_o,
   output logic       conflict_o
);

   logic [7:0] clash;

   for (genvar gi = 0; gi < 8; gi++) begin : g_bit
      // Undriven bits read as 0 rather than floating.
      assign uio_in_o[gi] = uio_oe_i[gi] ? uio_out_i[gi] : (uio_mask_i[gi] & uio_val_i[gi]);
      assign clash[gi]    = uio_oe_i[gi] & uio_mask_i[gi];
   end

   assign conflict_o = |clash;

endmodule

// File: rtl/tt_host_driver.sv
// ---------------------------------------------------------------------------
// tt_host_driver
// Fabric-side host for a TinyTapeout-style user project. Accepts one command
// at a time (SET_UI, SET_UIO, STEP, RESET), drives the project's inputs and
// clock enable, and returns a sample of the project's outputs for STEP/RESET.
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   bus        : command/response streams (slave side)
//   tt_ui_in   : to project UI_IN          tt_uo_out  : from project UO_OUT
//   tt_uio_in  : to project UIO_IN         tt_uio_out : from project UIO_OUT
//   tt_uio_oe  : from project UIO_OE       tt_ena     : project enable
//   tt_rst_n   : project reset (low)       tt_clk_en  : one project edge per high cycle
//   busy       : FSM not idle
// ---------------------------------------------------------------------------
module tt_host_driver
   import tt_host_pkg::*;
#(
   parameter int RESET_CYCLES = DEF_RESET_CYCLES,
   parameter int STEP_W       = DEF_STEP_W
) (
   input  logic                   clk,
   input  logic                   rst,
   tt_host_driver_if.slave        bus,
   output logic [7:0]             tt_ui_in,
   input  logic [7:0]             tt_uo_out,
   output logic [7:0]             tt_uio_in,
   input  logic [7:0]             tt_uio_out,
   input  logic [7:0]             tt_uio_oe,
   output logic                   tt_ena,
   output logic                   tt_rst_n,
   output logic                   tt_clk_en,
   output logic                   busy
);

   localparam logic [STEP_W-1:0] RST_LEN = STEP_W'(RESET_CYCLES);

   state_e            state_q;
   logic [STEP_W-1:0] cnt_q;
   logic [7:0]        ui_q;
   logic [7:0]        uio_val_q;
   logic [7:0]        uio_mask_q;
   logic              conflict_q;
   logic              rsp_valid_q;
   rsp_t              rsp_q;
   logic              cmd_ready_q;
   logic              busy_q;
   logic              ena_q;
   logic              rst_n_q;
   logic              clk_en_q;

   logic [7:0]        uio_res;
   logic              conflict_now;
   logic              accept;
   logic              rsp_hs;
   logic [STEP_W-1:0] rst_len_d;
   rsp_t              sample_d;

   tt_uio_resolve u_resolve (
      .uio_oe_i   (tt_uio_oe),
      .uio_out_i  (tt_uio_out),
      .uio_mask_i (uio_mask_q),
      .uio_val_i  (uio_val_q),
      .uio_in_o   (uio_res),
      .conflict_o (conflict_now)
   );

   assign accept    = bus.cmd_valid && cmd_ready_q;
   assign rsp_hs    = rsp_valid_q && bus.rsp_ready;
   assign rst_len_d = (bus.cmd_data != '0) ? bus.cmd_data : RST_LEN;

   // Snapshot taken on the last cycle of a STEP/RESET; includes contention
   // first seen in that very cycle.
   always_comb begin
      sample_d          = '0;
      sample_d.uio      = uio_res;
      sample_d.uo       = tt_uo_out;
      sample_d.conflict = conflict_q | conflict_now;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_AUTO_RST;
         cnt_q       <= RST_LEN;
         ui_q        <= '0;
         uio_val_q   <= '0;
         uio_mask_q  <= '0;
         conflict_q  <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_q       <= '0;
         cmd_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         ena_q       <= 1'b0;
         rst_n_q     <= 1'b0;
         clk_en_q    <= 1'b0;
      end else begin
         ena_q <= 1'b1;
         // Sticky contention; the response handshake starts a new window.
         conflict_q <= rsp_hs ? conflict_now : (conflict_q | conflict_now);

         case (state_q)
            ST_AUTO_RST, ST_RST_HOLD, ST_STEP_RUN: begin
               // cnt_q holds the number of clock-enable cycles still owed.
               if (cnt_q != '0) begin
                  clk_en_q <= 1'b1;
                  cnt_q    <= cnt_q - 1'b1;
                  busy_q   <= 1'b1;
               end else begin
                  clk_en_q <= 1'b0;
                  rst_n_q  <= 1'b1;
                  if (state_q == ST_AUTO_RST) begin
                     state_q     <= ST_IDLE;
                     cmd_ready_q <= 1'b1;
                     busy_q      <= 1'b0;
                  end else begin
                     state_q     <= ST_RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_q       <= sample_d;
                     busy_q      <= 1'b1;
                  end
               end
            end

            ST_IDLE: begin
               busy_q <= 1'b0;
               if (accept) begin
                  case (bus.cmd_op)
                     OP_SET_UI: ui_q <= bus.cmd_data[7:0];
                     OP_SET_UIO: begin
                        uio_val_q  <= bus.cmd_data[7:0];
                        uio_mask_q <= bus.cmd_data[15:8];
                     end
                     OP_STEP: begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (bus.cmd_data == '0) begin
                           state_q     <= ST_RESP;
                           rsp_valid_q <= 1'b1;
                           rsp_q       <= sample_d;
                        end else begin
                           // First enable cycle is issued here, so the run
                           // state only owes N-1 more.
                           state_q  <= ST_STEP_RUN;
                           clk_en_q <= 1'b1;
                           cnt_q    <= bus.cmd_data - 1'b1;
                        end
                     end
                     OP_RESET: begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_RST_HOLD;
                        rst_n_q     <= 1'b0;
                        clk_en_q    <= 1'b1;
                        cnt_q       <= rst_len_d - 1'b1;
                     end
                  endcase
               end
            end

            ST_RESP: begin
               busy_q <= 1'b1;
               if (bus.rsp_ready) begin
                  state_q     <= ST_IDLE;
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end

            default: begin
               state_q <= ST_AUTO_RST;
               cnt_q   <= RST_LEN;
               rst_n_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cmd_ready    = cmd_ready_q;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_data     = {rsp_q.uio, rsp_q.uo};
   assign bus.rsp_conflict = rsp_q.conflict;

   assign tt_ui_in  = ui_q;
   assign tt_uio_in = uio_res;
   assign tt_ena    = ena_q;
   assign tt_rst_n  = rst_n_q;
   assign tt_clk_en = clk_en_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_tt_host_driver.sv
// ---------------------------------------------------------------------------
// tb_tt_host_driver
// Directed bench for tt_host_driver. The project model answers UO = ~UI and
// the bench drives the project's UIO_OUT/UIO_OE directly.
// ---------------------------------------------------------------------------
module tb_tt_host_driver;
   import tt_host_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tt_ui_in;
   logic [7:0] tt_uo_out;
   logic [7:0] tt_uio_in;
   logic [7:0] tt_uio_out;
   logic [7:0] tt_uio_oe;
   logic       tt_ena;
   logic       tt_rst_n;
   logic       tt_clk_en;
   logic       busy;

   int checks = 0;
   int errors = 0;

   tt_host_driver_if #(.STEP_W(16)) bus ();

   tt_host_driver #(.RESET_CYCLES(8), .STEP_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .tt_ui_in   (tt_ui_in),
      .tt_uo_out  (tt_uo_out),
      .tt_uio_in  (tt_uio_in),
      .tt_uio_out (tt_uio_out),
      .tt_uio_oe  (tt_uio_oe),
      .tt_ena     (tt_ena),
      .tt_rst_n   (tt_rst_n),
      .tt_clk_en  (tt_clk_en),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   assign tt_uo_out = ~tt_ui_in;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at the negedge where rst has just been released.
   task automatic check_auto_rst(input string tag);
      int n, en, rv, ena_bad;
      n = 0; en = 0; rv = 0; ena_bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.cmd_ready) break;
         n++;
         if (tt_clk_en && !tt_rst_n) en++;
         if (bus.rsp_valid) rv++;
         if (!tt_ena) ena_bad++;
      end
      check({tag, "_cycles"},  n, 8);
      check({tag, "_clk_en"},  en, 8);
      check({tag, "_no_rsp"},  rv, 0);
      check({tag, "_ena"},     ena_bad, 0);
      check({tag, "_ready"},   bus.cmd_ready, 1);
      check({tag, "_rst_n"},   tt_rst_n, 1);
      check({tag, "_en_off"},  tt_clk_en, 0);
      check({tag, "_busy"},    busy, 0);
      $display("auto-reset %s: %0d cycles, %0d enables", tag, n, en);
   endtask

   // Issue at a negedge with cmd_ready high; returns at the t+1 sample point.
   task automatic issue(input op_e op, input logic [15:0] data);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_data  = data;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      $display("cmd op=%0d data=%h", op, data);
   endtask

   task automatic wait_rsp(output int lat, output int en_cnt, output int low_cnt);
      lat = 1; en_cnt = 0; low_cnt = 0;
      while (!bus.rsp_valid && lat < 400) begin
         if (tt_clk_en) en_cnt++;
         if (!tt_rst_n) low_cnt++;
         @(negedge clk);
         lat++;
      end
      check("rsp_arrived", bus.rsp_valid, 1);
      $display("rsp data=%h conflict=%0d lat=%0d en=%0d rst_low=%0d",
               bus.rsp_data, bus.rsp_conflict, lat, en_cnt, low_cnt);
   endtask

   task automatic handshake(input string tag);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check({tag, "_ready_after"}, bus.cmd_ready, 1);
      check({tag, "_valid_after"}, bus.rsp_valid, 0);
   endtask

   initial begin
      int lat, en, low;
      rst           = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_SET_UI;
      bus.cmd_data  = '0;
      bus.rsp_ready = 1'b0;
      tt_uio_out    = 8'h00;
      tt_uio_oe     = 8'h00;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_rst_n",  tt_rst_n, 0);
      check("rst_clk_en", tt_clk_en, 0);
      check("rst_ena",    tt_ena, 0);
      check("rst_ready",  bus.cmd_ready, 0);
      check("rst_valid",  bus.rsp_valid, 0);
      check("rst_ui",     tt_ui_in, 8'h00);
      check("rst_busy",   busy, 0);
      rst = 1'b0;
      check_auto_rst("boot");

      // SET_UI then STEP 3
      issue(OP_SET_UI, 16'h00A5);
      check("setui_ui",    tt_ui_in, 8'hA5);
      check("setui_ready", bus.cmd_ready, 1);
      issue(OP_STEP, 16'd3);
      check("step3_busy", busy, 1);
      wait_rsp(lat, en, low);
      check("step3_lat",  lat, 4);
      check("step3_en",   en, 3);
      check("step3_data", bus.rsp_data, 16'h005A);
      check("step3_conf", bus.rsp_conflict, 0);
      handshake("step3");

      // STEP 0 with the response held back for 5 cycles
      issue(OP_STEP, 16'd0);
      wait_rsp(lat, en, low);
      check("step0_lat", lat, 1);
      check("step0_en",  en, 0);
      tt_uio_oe  = 8'hFF;
      tt_uio_out = 8'h77;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_data",  bus.rsp_data, 16'h005A);
         check("hold_ready", bus.cmd_ready, 0);
         check("hold_valid", bus.rsp_valid, 1);
      end
      tt_uio_oe  = 8'h00;
      tt_uio_out = 8'h00;
      handshake("step0");

      // SET_UIO with contention on bits 1:0
      tt_uio_oe  = 8'h03;
      tt_uio_out = 8'h02;
      issue(OP_SET_UIO, 16'h0F3C);
      check("uio_resolved", tt_uio_in, 8'h0E);
      issue(OP_STEP, 16'd1);
      wait_rsp(lat, en, low);
      check("conf_lat",  lat, 2);
      check("conf_data", bus.rsp_data, 16'h0E5A);
      check("conf_flag", bus.rsp_conflict, 1);
      tt_uio_oe  = 8'h00;
      tt_uio_out = 8'h00;
      handshake("conf");
      issue(OP_STEP, 16'd2);
      wait_rsp(lat, en, low);
      check("clr_data", bus.rsp_data, 16'h0C5A);
      check("clr_flag", bus.rsp_conflict, 0);
      handshake("clr");

      // RESET with default and explicit lengths
      issue(OP_RESET, 16'd0);
      wait_rsp(lat, en, low);
      check("rst0_low",   low, 8);
      check("rst0_en",    en, 8);
      check("rst0_lat",   lat, 9);
      check("rst0_rst_n", tt_rst_n, 1);
      check("rst0_data",  bus.rsp_data, 16'h0C5A);
      handshake("rst0");
      check("rst0_ui", tt_ui_in, 8'hA5);
      issue(OP_RESET, 16'd3);
      wait_rsp(lat, en, low);
      check("rst3_low", low, 3);
      check("rst3_lat", lat, 4);
      handshake("rst3");
      check("rst3_ui",  tt_ui_in, 8'hA5);
      check("rst3_uio", tt_uio_in, 8'h0C);

      // rst in the middle of STEP 100
      issue(OP_STEP, 16'd100);
      repeat (4) @(negedge clk);
      check("mid_clk_en", tt_clk_en, 1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_en_drop", tt_clk_en, 0);
      check("mid_valid",   bus.rsp_valid, 0);
      check("mid_ui",      tt_ui_in, 8'h00);
      check("mid_rst_n",   tt_rst_n, 0);
      @(negedge clk);
      rst = 1'b0;
      check_auto_rst("mid");
      check("mid_uio_mask", tt_uio_in, 8'h00);
      check("mid_ui_after", tt_ui_in, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
